// File: rtl/avr_irqctl_pkg.sv
// Shared constants and types for the AVR-style interrupt controller.
// Holds source count, register offsets, IRQCTL bit positions and FSM states.
package avr_irqctl_pkg;

   localparam int NUM_IRQ = 8;

   localparam logic [1:0] A_EN   = 2'd0;
   localparam logic [1:0] A_PND  = 2'd1;
   localparam logic [1:0] A_EDGE = 2'd2;
   localparam logic [1:0] A_CTL  = 2'd3;

   localparam int CTL_GIE  = 7;
   localparam int CTL_BUSY = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SVC
   } state_t;

endpackage

// File: rtl/avr_irqctl_if.sv
// I/O register bus between the CPU (master) and the controller (slave).
// Ports: io_re/io_we strobes, io_a select, io_di write data, io_do read data.
interface avr_irqctl_if;

   logic       io_re;
   logic       io_we;
   logic [1:0] io_a;
   logic [7:0] io_di;
   logic [7:0] io_do;

   modport master (
      output io_re, io_we, io_a, io_di,
      input  io_do
   );

   modport slave (
      input  io_re, io_we, io_a, io_di,
      output io_do
   );

endinterface

// File: rtl/avr_irq_prio.sv
// Combinational 8-to-3 priority encoder; lowest set index wins.
// Ports: req (8 lines in), idx (winning index), valid (any line set).
module avr_irq_prio
   import avr_irqctl_pkg::*;
(
   input  logic [NUM_IRQ-1:0] req,
   output logic [2:0]         idx,
   output logic               valid
);

   // Scan downward so the lowest set index is the last assignment.
   always_comb begin
      idx   = '0;
      valid = |req;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) idx = 3'(i);
      end
   end

endmodule

// File: rtl/avr_irqctl.sv
// Eight-source interrupt controller with edge/level pending and a REQ/ACK/RETI FSM.
// Ports: clk, rst (async active-low), bus (I/O regs), irq_in, irq_req/irq_vec, irq_ack, irq_ret.
module avr_irqctl
   import avr_irqctl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   avr_irqctl_if.slave        bus,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq_req,
   output logic [2:0]         irq_vec,
   input  logic               irq_ack,
   input  logic               irq_ret
);

   logic [NUM_IRQ-1:0] en;
   logic [NUM_IRQ-1:0] edge_sel;
   logic [NUM_IRQ-1:0] pnd_e;
   logic [NUM_IRQ-1:0] irq_q;
   logic               gie;
   logic [2:0]         vec;
   state_t             state;

   logic               wr;
   logic [NUM_IRQ-1:0] set;
   logic [NUM_IRQ-1:0] wr_clr;
   logic [NUM_IRQ-1:0] ack_clr;
   logic [NUM_IRQ-1:0] pnd;
   logic [NUM_IRQ-1:0] cand;
   logic [2:0]         cand_idx;
   logic               cand_valid;
   logic               busy;
   logic [7:0]         ctl;

   assign wr   = bus.io_we & ~bus.io_re;
   assign busy = (state != ST_IDLE);
   assign set  = irq_in & ~irq_q & edge_sel;

   // Level sources read straight through; edge sources read the latch.
   assign pnd  = (edge_sel & pnd_e) | (~edge_sel & irq_in);
   assign cand = pnd & en;

   always_comb begin
      wr_clr = '0;
      if (wr && bus.io_a == A_PND) wr_clr = bus.io_di;
   end

   always_comb begin
      ack_clr = '0;
      if (state == ST_REQ && irq_ack) ack_clr[vec] = 1'b1;
   end

   always_comb begin
      ctl           = '0;
      ctl[CTL_GIE]  = gie;
      ctl[CTL_BUSY] = busy;
      ctl[2:0]      = vec;
   end

   always_comb begin
      bus.io_do = '0;
      if (bus.io_re) begin
         unique case (bus.io_a)
            A_EN:   bus.io_do = en;
            A_PND:  bus.io_do = pnd;
            A_EDGE: bus.io_do = edge_sel;
            A_CTL:  bus.io_do = ctl;
         endcase
      end
   end

   avr_irq_prio u_prio (
      .req   (cand),
      .idx   (cand_idx),
      .valid (cand_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en       <= '0;
         edge_sel <= '0;
         pnd_e    <= '0;
         irq_q    <= '0;
         gie      <= 1'b0;
      end else begin
         irq_q <= irq_in;
         // A new edge beats any clear arriving on the same edge.
         pnd_e <= (pnd_e & ~(wr_clr | ack_clr)) | set;
         if (wr) begin
            unique case (bus.io_a)
               A_EN:   en       <= bus.io_di;
               A_PND:  ;
               A_EDGE: edge_sel <= bus.io_di;
               A_CTL:  gie      <= bus.io_di[CTL_GIE];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         irq_req <= 1'b0;
         vec     <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (gie && cand_valid) begin
                  state   <= ST_REQ;
                  irq_req <= 1'b1;
                  vec     <= cand_idx;
               end
            end
            ST_REQ: begin
               if (irq_ack) begin
                  state   <= ST_SVC;
                  irq_req <= 1'b0;
               end
            end
            ST_SVC: begin
               if (irq_ret) state <= ST_IDLE;
            end
            default: begin
               state   <= ST_IDLE;
               irq_req <= 1'b0;
            end
         endcase
      end
   end

   assign irq_vec = vec;

endmodule

// File: doc/avr_irqctl.md
AVR_IRQCTL -- requirements
Module: avr_irqctl

Interface
REQ-001 Port list: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
REQ-002 I/O bus ports (responder side):
- io_re  in  1  read strobe.
- io_we  in  1  write strobe.
- io_a  in  2  register select.
- io_di  in  8  write data.
- io_do  out  8  read data.
REQ-003 Peripheral and CPU ports:
- irq_in  in  8  peripheral interrupt lines; bit 0 is highest priority.
- irq_req  out  1  interrupt request to the CPU.
- irq_vec  out  3  index of the requested source; valid while irq_req=1.
- irq_ack  in  1  single-cycle CPU accept pulse.
- irq_ret  in  1  single-cycle CPU return-from-interrupt (RETI) pulse.

Function
REQ-004 Register map:
- 0 IRQEN r/w: per-source enable.
- 1 IRQPND r: pending; write of 1 clears edge-mode bits only.
- 2 IRQEDGE r/w: 1 = rising-edge latched, 0 = level.
- 3 IRQCTL r: {GIE, BUSY, 3'b000, VEC[2:0]}; write: bit7 -> GIE, other bits ignored.
REQ-005 io_do SHALL be combinational from io_a while io_re=1, else 8'h00.
REQ-006 Writes SHALL take effect on the clock edge where io_we=1 and io_re=0; io_we with io_re=1 is ignored.
REQ-007 Edge mode: irq_in SHALL be registered once; the pending bit sets on a cycle where irq_in=1 and the registered value=0.
REQ-008 Level mode: pending bit = live irq_in bit; a write-1-clear has no effect on it.
REQ-009 Same-cycle edge set and software clear on one bit: set SHALL win.
REQ-010 Candidate = IRQPND & IRQEN; the selected source is the lowest-index set bit.
REQ-011 FSM states: IDLE, REQ, SERVICE.
- IDLE->REQ when GIE=1 and candidate!=0; VEC is latched on that edge.
- REQ->SERVICE on irq_ack.
- SERVICE->IDLE on irq_ret.
REQ-012 irq_req SHALL be 1 exactly in REQ; it asserts the cycle after the candidate appears, a latency of 1 clock.
REQ-013 In REQ, irq_req and irq_vec SHALL hold stable until irq_ack, even if the source deasserts, is disabled, or GIE clears; no withdrawal.
REQ-014 On the irq_ack edge, the edge-mode pending bit of VEC SHALL clear, unless REQ-009 applies.
REQ-015 BUSY = state != IDLE; no nesting, so new candidates wait in IRQPND until IDLE.
REQ-016 irq_ack outside REQ and irq_ret outside SERVICE SHALL be ignored.
REQ-017 IRQCTL.VEC SHALL show the last latched vector; it updates only on IDLE->REQ.

Reset
REQ-018 While rst=0:
- IRQEN, IRQPND edge bits, IRQEDGE, GIE, VEC and the edge-detect register = 0.
- state = IDLE; irq_req = 0; irq_vec = 0.
REQ-019 Reset mid-REQ/SERVICE SHALL drop irq_req asynchronously; no pending state survives.
REQ-020 The edge-detect register resets to 0, so an irq_in already high at reset release is latched as an edge.

Structure
REQ-021 Package avr_irqctl_pkg SHALL hold NUM_IRQ=8, the register offsets, the IRQCTL bit positions, and the state enum.
REQ-022 Sub-module avr_irq_prio SHALL be the combinational 8-to-3 lowest-index priority encoder with a valid flag.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- IRQEN=0x01, IRQEDGE=0x01, GIE=1, pulse irq_in[0] -> irq_req 1 clock later, vec=0; ack -> IRQPND=0x00, BUSY=1; ret -> BUSY=0.
- irq_in=0x0C level, IRQEN=0xFF, GIE=1 -> vec=2; after ack+ret with irq_in still 0x0C -> vec=2 requested again.
- Edge bit 5 pending, GIE=1, clear IRQEN during REQ -> irq_req held, vec=5 until ack.
- Write IRQPND=0x10 on the same cycle as an irq_in[4] rising edge (edge mode) -> IRQPND[4]=1.
- Rst low during SERVICE -> irq_req=0, all registers 0x00, IRQCTL=0x00.
- io_re=0 with any io_a -> io_do=0x00; read of addr 3 in REQ with vec=6 -> 0xC6.
